// File: rtl/bmu_result_capture.sv
// bmu_result_capture
// Captures each issued BMU operation together with its registered result one
// cycle later and queues the completed transaction in a small FIFO that a
// downstream checker or trace port drains with a valid/ready handshake.
// Also keeps a sticky overflow flag for dropped entries and a saturating count
// of captured entries that carried an error.
module bmu_result_capture #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     rstL,
  input  logic                     validIn,
  input  logic [41:0]              ap,
  input  logic [31:0]              aIn,
  input  logic [31:0]              bIn,
  input  logic [31:0]              resultFf,
  input  logic                     error,
  input  logic                     clrIn,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [31:0]              outA,
  output logic [31:0]              outB,
  output logic [31:0]              outResult,
  output logic                     outError,
  output logic [5:0]               outOpIdx,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNTW-1:0]          errCount
);

  localparam int AW = $clog2(DEPTH);

  // Stage register holding the issued operation until its result arrives
  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic [5:0]  s1_op;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [31:0] mem_a   [DEPTH];
  logic [31:0] mem_b   [DEPTH];
  logic [31:0] mem_res [DEPTH];
  logic        mem_err [DEPTH];
  logic [5:0]  mem_op  [DEPTH];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic [5:0] op_idx;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       push_ok;
  logic       drop;
  logic       err_inc;

  // Index of the most significant set bit of the op packet; 63 when no op bit is set
  always_comb begin
    op_idx = 6'd63;
    for (int i = 0; i < 42; i++) begin
      if (ap[i]) op_idx = 6'(i);
    end
  end

  assign wr_idx     = wr_ptr[AW-1:0];
  assign rd_idx     = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);

  // A full FIFO still accepts a push when the head leaves on the same edge;
  // the slot being written is the one being vacated, so no data is lost.
  assign pop      = !fifo_empty && outReady;
  assign push_ok  = s1_valid && (!fifo_full || pop);
  assign drop     = s1_valid && fifo_full && !pop;
  assign err_inc  = push_ok && error && (errCount != {CNTW{1'b1}});

  // Stage register: reload on every issued op, otherwise just invalidate
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= validIn;
      if (validIn) begin
        s1_a  <= aIn;
        s1_b  <= bIn;
        s1_op <= op_idx;
      end
    end
  end

  // FIFO payload write; contents are masked at the outputs so need no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_a[wr_idx]   <= s1_a;
      mem_b[wr_idx]   <= s1_b;
      mem_res[wr_idx] <= resultFf;
      mem_err[wr_idx] <= error;
      mem_op[wr_idx]  <= s1_op;
    end
  end

  // Pointer update for accepted pushes and pops
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow and saturating error counter; clear has priority
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else if (clrIn) begin
      overflow <= 1'b0;
      errCount <= '0;
    end else begin
      if (drop)    overflow <= 1'b1;
      if (err_inc) errCount <= errCount + 1'b1;
    end
  end

  // Head entry presentation, zeroed whenever the FIFO is empty
  always_comb begin
    outValid  = !fifo_empty;
    level     = wr_ptr - rd_ptr;
    outA      = '0;
    outB      = '0;
    outResult = '0;
    outError  = 1'b0;
    outOpIdx  = '0;
    if (!fifo_empty) begin
      outA      = mem_a[rd_idx];
      outB      = mem_b[rd_idx];
      outResult = mem_res[rd_idx];
      outError  = mem_err[rd_idx];
      outOpIdx  = mem_op[rd_idx];
    end
  end

endmodule

// File: tb/tb_bmu_result_capture.sv
// Bench for bmu_result_capture: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level queue model.
module tb_bmu_result_capture;

  localparam int DEPTH = 4;
  localparam int CNTW  = 5;
  localparam int EMAX  = (1 << CNTW) - 1;

  logic        clk = 1'b0;
  logic        rstL;
  logic        validIn;
  logic [41:0] ap;
  logic [31:0] aIn, bIn, resultFf;
  logic        error, clrIn, outReady;
  logic        outValid;
  logic [31:0] outA, outB, outResult;
  logic        outError;
  logic [5:0]  outOpIdx;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [CNTW-1:0] errCount;

  bmu_result_capture #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rstL(rstL), .validIn(validIn), .ap(ap), .aIn(aIn), .bIn(bIn),
    .resultFf(resultFf), .error(error), .clrIn(clrIn), .outReady(outReady),
    .outValid(outValid), .outA(outA), .outB(outB), .outResult(outResult),
    .outError(outError), .outOpIdx(outOpIdx), .level(level),
    .overflow(overflow), .errCount(errCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
    logic [5:0]  op;
  } ent_t;

  ent_t q[$];
  ent_t pend;
  bit   pend_v;
  bit   m_ovf;
  int   m_err;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // floor(log2(ap)) by repeated halving, 63 when no bit set
  function automatic logic [5:0] ref_op(input logic [41:0] p);
    longint unsigned x = 64'(p);
    int n = 0;
    if (x == 0) return 6'd63;
    while (x > 1) begin
      x = x >> 1;
      n++;
    end
    return 6'(n);
  endfunction

  function automatic void model_reset();
    q.delete();
    pend_v = 0;
    m_ovf  = 0;
    m_err  = 0;
  endfunction

  // Transaction-level effect of one clock edge given the current inputs
  function automatic void model_edge();
    bit pop  = (q.size() > 0) && outReady;
    bit pushed = 0;
    bit dropped = 0;
    ent_t e;
    if (pop) void'(q.pop_front());
    if (pend_v) begin
      e.a = pend.a; e.b = pend.b; e.op = pend.op; e.r = resultFf; e.e = error;
      if (q.size() < DEPTH) begin
        q.push_back(e);
        pushed = 1;
      end else dropped = 1;
    end
    if (clrIn) begin
      m_ovf = 0;
      m_err = 0;
    end else begin
      if (dropped) m_ovf = 1;
      if (pushed && error && m_err < EMAX) m_err++;
    end
    pend_v = validIn;
    if (validIn) begin
      pend.a = aIn; pend.b = bIn; pend.op = ref_op(ap);
    end
  endfunction

  task automatic check_all(input string ctx);
    chk({ctx, ".outValid"}, 64'(outValid), 64'(q.size() > 0));
    chk({ctx, ".level"},    64'(level),    64'(q.size()));
    chk({ctx, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({ctx, ".errCount"}, 64'(errCount), 64'(m_err));
    if (q.size() > 0) begin
      chk({ctx, ".outA"},      64'(outA),      64'(q[0].a));
      chk({ctx, ".outB"},      64'(outB),      64'(q[0].b));
      chk({ctx, ".outResult"}, 64'(outResult), 64'(q[0].r));
      chk({ctx, ".outError"},  64'(outError),  64'(q[0].e));
      chk({ctx, ".outOpIdx"},  64'(outOpIdx),  64'(q[0].op));
    end else begin
      chk({ctx, ".outData0"},
          {outA | outB | outResult, 25'd0, outError, outOpIdx}, 64'd0);
    end
  endtask

  task automatic step(input string ctx, input bit v, input logic [41:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input bit e, input bit rdy, input bit clr);
    @(negedge clk);
    validIn = v; ap = p; aIn = a; bIn = b; resultFf = r;
    error = e; outReady = rdy; clrIn = clr;
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  function automatic logic [41:0] onehot(input int k);
    logic [41:0] p = '0;
    p[k] = 1'b1;
    return p;
  endfunction

  function automatic logic [41:0] rand_ap();
    logic [41:0] p = '0;
    int k;
    if ($urandom_range(0, 9) == 0) return p;
    k = $urandom_range(0, 41);
    p[k] = 1'b1;
    if ($urandom_range(0, 3) == 0) p[$urandom_range(0, k)] = 1'b1;
    return p;
  endfunction

  logic [31:0] prev_r;

  initial begin
    rstL = 1'b0; validIn = 0; ap = '0; aIn = '0; bIn = '0; resultFf = '0;
    error = 0; clrIn = 0; outReady = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rstL = 1'b1;

    // Single op: add (bit 9), 5 + 7
    step("single_issue", 1, onehot(9), 32'd5, 32'd7, 32'd0, 0, 0, 0);
    step("single_cap",   0, '0, 32'd0, 32'd0, 32'd12, 0, 0, 0);
    chk("single_level", 64'(level), 64'd1);
    chk("single_opidx", 64'(outOpIdx), 64'd9);
    chk("single_res",   64'(outResult), 64'd12);
    step("single_pop",   0, '0, 32'd0, 32'd0, 32'd0, 0, 1, 0);

    // Burst fill: 6 back-to-back ops, consumer stalled
    for (int i = 0; i < 6; i++)
      step("burst", 1, onehot(41 - i), 32'(100 + i), 32'(200 + i),
           32'(1000 + i - 1), 0, 0, 0);
    step("burst_last", 0, '0, 32'd0, 32'd0, 32'd1005, 0, 0, 0);
    chk("burst_level", 64'(level), 64'(DEPTH));
    chk("burst_ovf",   64'(overflow), 64'd1);
    chk("burst_head",  64'(outA), 64'd100);
    step("burst_clr", 0, '0, 32'd0, 32'd0, 32'd0, 0, 0, 1);
    chk("clr_ovf", 64'(overflow), 64'd0);

    // Full with simultaneous push and pop
    step("fullpp_issue", 1, onehot(3), 32'hAA, 32'hBB, 32'd0, 0, 0, 0);
    step("fullpp_cap",   0, '0, 32'd0, 32'd0, 32'hCC, 0, 1, 0);
    chk("fullpp_level", 64'(level), 64'(DEPTH));
    chk("fullpp_ovf",   64'(overflow), 64'd0);
    chk("fullpp_head",  64'(outA), 64'd101);
    for (int i = 0; i < DEPTH + 1; i++)
      step("drain", 0, '0, 32'd0, 32'd0, 32'd0, 0, 1, 0);

    // Error counting: 3 errors, 1 clean
    prev_r = 0;
    for (int i = 0; i < 5; i++)
      step("err", i < 4, onehot(i), 32'(i), 32'(i), 32'(50 + i),
           (i >= 1 && i <= 3), 1, 0);
    chk("err_count3", 64'(errCount), 64'd3);
    // Saturation
    for (int i = 0; i < EMAX + 6; i++)
      step("err_sat", 1, onehot(20), 32'(i), 32'(i), 32'(i), 1, 1, 0);
    chk("err_sat", 64'(errCount), 64'(EMAX));
    // Clear coinciding with an error push
    step("err_clr", 0, '0, 32'd0, 32'd0, 32'd9, 1, 1, 1);
    chk("err_clr0", 64'(errCount), 64'd0);
    step("err_idle", 0, '0, 32'd0, 32'd0, 32'd0, 0, 1, 0);

    // Wrap-around: 10 single ops, each popped
    for (int i = 0; i < 10; i++) begin
      step("wrap_issue", 1, onehot(i), 32'(i), 32'(~i), 32'd0, 0, 1, 0);
      step("wrap_cap",   0, '0, 32'd0, 32'd0, 32'(7000 + i), 0, 1, 0);
      chk("wrap_res", 64'(outResult), 64'(7000 + i));
    end
    step("wrap_end", 0, '0, 32'd0, 32'd0, 32'd0, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 9) < 7, rand_ap(), $urandom, $urandom, $urandom,
           $urandom_range(0, 9) < 3, $urandom_range(0, 1), $urandom_range(0, 19) == 0);

    // Async reset mid-burst, asserted between edges
    for (int i = 0; i < 3; i++)
      step("prerst", 1, onehot(7), 32'(i), 32'(i), 32'(i), 1, 0, 0);
    @(negedge clk);
    #2;
    rstL = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    validIn = 0; ap = '0; resultFf = 32'h1234; error = 1; outReady = 0; clrIn = 0;
    rstL = 1'b1;
    step("post_rst_orphan", 0, '0, 32'd0, 32'd0, 32'h5555, 1, 0, 0);
    chk("orphan_level", 64'(level), 64'd0);
    step("post_rst_issue", 1, onehot(9), 32'd1, 32'd2, 32'd0, 0, 0, 0);
    step("post_rst_cap",   0, '0, 32'd0, 32'd0, 32'd3, 0, 0, 0);
    chk("post_rst_level", 64'(level), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bmu_result_capture.md
# bmu_result_capture

Hardware capture block on the consumer side of the BMU stimulus/result interface. It samples every accepted BMU operation (`validIn` with its operands and one-hot op packet) and pairs it with the BMU's registered `resultFf`/`error` one cycle later. Each completed transaction is pushed into a small FIFO, which a downstream checker or trace port drains through a valid/ready handshake. It also keeps a sticky overflow flag and a saturating error counter.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNTW, 16, width of the error counter

Ports:
- clk  input  1  single clock, all state on posedge
- rstL  input  1  asynchronous active-low reset
- validIn  input  1  BMU operation issued this cycle
- ap  input  42  one-hot BMU op packet; bit 41 = clz … bit 0 = csr_imm (field order clz, ctz, cpop, … csr_write, csr_imm)
- aIn  input  32  operand A
- bIn  input  32  operand B
- resultFf  input  32  BMU registered result, valid one cycle after validIn
- error  input  1  BMU error, aligned with resultFf
- clrIn  input  1  synchronous clear of overflow flag and error counter
- outReady  input  1  consumer accepts head entry
- outValid  output  1  FIFO non-empty
- outA  output  32  head entry operand A
- outB  output  32  head entry operand B
- outResult  output  32  head entry result
- outError  output  1  head entry error
- outOpIdx  output  6  head entry op index
- level  output  log2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: an entry was dropped
- errCount  output  CNTW  saturating count of captured entries with error=1

## Operation
- Stage register (S1): on each posedge with validIn=1, load aIn, bIn, and opIdx; set s1Valid=1. With validIn=0, clear s1Valid. Back-to-back validIn reloads S1 every cycle.
- opIdx = bit position of the most significant set bit of ap. It is 63 if ap==0. Example: clz alone gives 41; add alone gives bit position of add (9). Multiple set bits (op+modifier) still take the MSB.
- Push: when s1Valid=1, the entry {S1 fields, resultFf, error} is written at the write pointer on that posedge.
- Pop: outValid && outReady advances the read pointer.
- FIFO is a circular buffer with DEPTH entries and log2(DEPTH)+1-bit pointers. Pointers wrap modulo DEPTH. Full means the low bits are equal and the MSBs differ.
- Push when full and no pop: the entry is dropped, overflow is set, and pointers are unchanged.
- Push when full with a pop in the same cycle: both succeed, no drop, and level is unchanged.
- Push when empty with outReady=1: the entry is written and not popped the same cycle (no fall-through).
- errCount increments by 1 for each successfully pushed entry with error=1, saturating at all-ones. Dropped entries do not count.
- clrIn=1 clears overflow and errCount. If clrIn coincides with an increment or a drop, clear wins. FIFO contents are unaffected.
- outA/outB/outResult/outError/outOpIdx present the head entry when outValid=1, and are forced to 0 when outValid=0.

## Timing
- Reset (rstL low, asynchronous assert, synchronous-to-clk deassert sampling):
  - s1Valid=0, pointers=0, outValid=0, level=0.
  - All data outputs are 0; overflow=0, errCount=0.
- Latency: validIn at edge N → entry written at edge N+1 → outValid=1 after edge N+1.
- Throughput: one capture per cycle sustained when outReady=1 continuously.
- level updates on the same edge as push/pop.
- Reset mid-operation discards S1 and all FIFO contents. A resultFf arriving the cycle after deassert without a prior validIn is not captured.

## Test plan
- Single op: validIn=1, ap=add only, aIn=5, bIn=7; next cycle resultFf=12, error=0 → outValid=1 one cycle later with outA=5, outB=7, outResult=12, outOpIdx=9, outError=0, level=1.
- Burst fill: DEPTH+2=6 back-to-back ops with outReady=0 → level=4, overflow=1, and the FIFO holds the first 4 entries in order. Then clrIn=1 → overflow=0.
- Full with simultaneous push/pop: FIFO full, outReady=1, new capture → level stays 4, no overflow, and the head advances by one.
- Error counting: 3 ops with error=1 and 1 with error=0 → errCount=3. Force errCount to 0xFFFF (CNTW=16) and add more errors → it stays at 0xFFFF. clrIn asserted together with an error push → errCount=0.
- Wrap-around: 10 single ops each popped immediately → pointers wrap twice, and each outResult matches in order.
- Async reset: assert rstL=0 mid-burst between clock edges → outValid, level, overflow, errCount and data outputs go to 0 immediately. The first capture after release lands at level=1.
